// File: rtl/cache_region_wrap.sv
// cache_region_wrap: routes CPU accesses to the data cache or down an uncached path to memory
// Ports: clk/rst (sync, active-high); CPU request (addr/wdata/wmask/wen/ren_cpu) with
// rdata_cpu/stall_cpu back; cache_enable requests the mode, cache_en_q is the mode in force;
// cache_wen/ren gate the cache, cache_rdata/cache_hit come back; cm_* is the cache's memory
// master, forwarded to mem_* whenever no uncached access owns the port; uc_count counts
// completed uncached accesses.
module cache_region_wrap #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_WORDS = 2,
  parameter int NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK = '0,
  parameter int CNT_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ADDR_WIDTH-1:0]                addr_cpu,
  input  logic [DATA_WIDTH-1:0]                wdata_cpu,
  input  logic [DATA_WIDTH/8-1:0]              wmask_cpu,
  input  logic                                 wen_cpu,
  input  logic                                 ren_cpu,
  output logic [DATA_WIDTH-1:0]                rdata_cpu,
  output logic                                 stall_cpu,
  input  logic                                 cache_enable,
  output logic                                 cache_en_q,
  output logic                                 cache_wen,
  output logic                                 cache_ren,
  input  logic [DATA_WIDTH-1:0]                cache_rdata,
  input  logic                                 cache_hit,
  input  logic [ADDR_WIDTH-1:0]                cm_raddr,
  input  logic                                 cm_ren,
  input  logic [ADDR_WIDTH-1:0]                cm_waddr,
  input  logic                                 cm_wen,
  input  logic [DATA_WIDTH*LINE_WORDS-1:0]     cm_wdata,
  input  logic [DATA_WIDTH*LINE_WORDS/8-1:0]   cm_wmask,
  output logic                                 cm_rvalid,
  output logic [DATA_WIDTH*LINE_WORDS-1:0]     cm_rdata,
  output logic                                 cm_wvalid,
  output logic [ADDR_WIDTH-1:0]                mem_raddr,
  output logic                                 mem_ren,
  output logic [ADDR_WIDTH-1:0]                mem_waddr,
  output logic                                 mem_wen,
  output logic [DATA_WIDTH*LINE_WORDS-1:0]     mem_wdata,
  output logic [DATA_WIDTH*LINE_WORDS/8-1:0]   mem_wmask,
  input  logic                                 mem_rvalid,
  input  logic [DATA_WIDTH*LINE_WORDS-1:0]     mem_rdata,
  input  logic                                 mem_wvalid,
  output logic [CNT_WIDTH-1:0]                 uc_count
);
  localparam int BN = DATA_WIDTH/8;
  localparam int LW = DATA_WIDTH*LINE_WORDS;
  localparam int MW = LW/8;
  localparam int LSB = $clog2(BN);
  localparam int LB = $clog2(LINE_WORDS);
  localparam int DB = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, UC_WAIT, UC_RD, UC_WR, UC_RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LW-1:0] wdata_q;
  logic [MW-1:0] wmask_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [NUM_REGIONS-1:0] hit;
  logic idle, uc, req, pend, busy, cm_busy, uncached, fwd, launch, latch;
  logic [LB-1:0] lane, lane_q;
  genvar i;
  for (i = 0; i < NUM_REGIONS; i++) begin : g_region
    assign hit[i] = (|REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
      ((addr_cpu & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
       (REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]));
  end
  assign idle = state_q == IDLE;
  assign uc = state_q == UC_RD || state_q == UC_WR;
  assign req = wen_cpu | ren_cpu;
  // A mode change is pending; requests wait until it lands so routing never flips mid-access.
  assign pend = cache_enable != cache_en_q;
  // The cache still has a memory transaction that has not received its response this cycle.
  assign busy = cm_ren & ~mem_rvalid | cm_wen & ~mem_wvalid;
  assign cm_busy = cm_ren | cm_wen;
  assign uncached = ~cache_en_q | (|hit);
  assign fwd = idle & ~pend & ~uncached;
  assign launch = idle & req & ~pend & uncached;
  assign latch = (launch | state_q == UC_WAIT) & ~cm_busy;
  assign lane = addr_cpu[LSB +: LB];
  assign lane_q = addr_q[LSB +: LB];
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = cm_busy ? UC_WAIT : wen_cpu ? UC_WR : UC_RD;
      UC_WAIT: if (!cm_busy) state_d = wen_cpu ? UC_WR : UC_RD;
      UC_RD,
      UC_WR:   if (mem_rvalid | mem_wvalid) state_d = UC_RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cache_en_q <= 1'b0;
      cnt_q <= '0;
      rdata_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      if (idle & ~busy) cache_en_q <= cache_enable;
      if (latch) begin
        addr_q <= addr_cpu;
        wdata_q <= {LINE_WORDS{wdata_cpu}};
        wmask_q <= MW'(wmask_cpu) << {lane, {LSB{1'b0}}};
      end
      if (state_q == UC_RD && mem_rvalid) rdata_q <= mem_rdata[{lane_q, {DB{1'b0}}} +: DATA_WIDTH];
      if (state_q == UC_RESP) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end
  assign mem_raddr = uc ? addr_q : cm_raddr;
  assign mem_waddr = uc ? addr_q : cm_waddr;
  assign mem_wdata = uc ? wdata_q : cm_wdata;
  assign mem_wmask = uc ? wmask_q : cm_wmask;
  assign mem_ren = uc ? state_q == UC_RD : cm_ren;
  assign mem_wen = uc ? state_q == UC_WR : cm_wen;
  assign cm_rvalid = ~uc & mem_rvalid;
  assign cm_wvalid = ~uc & mem_wvalid;
  assign cm_rdata = mem_rdata;
  assign cache_wen = fwd & wen_cpu;
  assign cache_ren = fwd & ren_cpu & ~wen_cpu;
  assign stall_cpu = idle ? req & (pend | uncached | ~cache_hit) : state_q != UC_RESP;
  assign rdata_cpu = state_q == UC_RESP ? rdata_q : cache_rdata;
  assign uc_count = cnt_q;
endmodule

// File: tb/tb_cache_region_wrap.sv
// tb_cache_region_wrap: scoreboard bench for cache_region_wrap routing, uncached FSM and mode switch
module tb_cache_region_wrap;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [63:0] addr_cpu = '0, wdata_cpu = '0, rdata_cpu, cache_rdata = '0;
  logic [7:0] wmask_cpu = '0;
  logic wen_cpu = 0, ren_cpu = 0, stall_cpu, cache_enable = 0, cache_en_q;
  logic cache_wen, cache_ren, cache_hit = 0;
  logic [63:0] cm_raddr = '0, cm_waddr = '0, mem_raddr, mem_waddr;
  logic cm_ren = 0, cm_wen = 0, cm_rvalid, cm_wvalid, mem_ren, mem_wen;
  logic mem_rvalid = 0, mem_wvalid = 0;
  logic [127:0] cm_wdata = '0, cm_rdata, mem_wdata, mem_rdata = '0;
  logic [15:0] cm_wmask = '0, mem_wmask;
  logic [31:0] uc_count;
  int total = 0, bad = 0, exp_uc = 0;
  logic [63:0] sb[$];
  cache_region_wrap #(
    .REGION_BASE({64'h0, 64'h1000_0000}),
    .REGION_MASK({64'h0, 64'hF000_0000})
  ) dut (
    .clk(clk), .rst(rst),
    .addr_cpu(addr_cpu), .wdata_cpu(wdata_cpu), .wmask_cpu(wmask_cpu), .wen_cpu(wen_cpu), .ren_cpu(ren_cpu),
    .rdata_cpu(rdata_cpu), .stall_cpu(stall_cpu), .cache_enable(cache_enable), .cache_en_q(cache_en_q),
    .cache_wen(cache_wen), .cache_ren(cache_ren), .cache_rdata(cache_rdata), .cache_hit(cache_hit),
    .cm_raddr(cm_raddr), .cm_ren(cm_ren), .cm_waddr(cm_waddr), .cm_wen(cm_wen), .cm_wdata(cm_wdata),
    .cm_wmask(cm_wmask), .cm_rvalid(cm_rvalid), .cm_rdata(cm_rdata), .cm_wvalid(cm_wvalid),
    .mem_raddr(mem_raddr), .mem_ren(mem_ren), .mem_waddr(mem_waddr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_wvalid(mem_wvalid), .uc_count(uc_count)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #2;
  endtask
  task automatic pop_check(input string tag);
    check({tag, "_sb"}, 128'(sb.size() != 0), 128'(1));
    if (sb.size() != 0) check(tag, rdata_cpu, sb.pop_front());
  endtask
  task automatic uc_go(input logic [63:0] a, input logic w, input logic [63:0] d, input logic [7:0] m,
                       input int lat, input logic [127:0] line);
    addr_cpu = a; wen_cpu = w; ren_cpu = !w; wdata_cpu = d; wmask_cpu = m;
    if (!w) sb.push_back(a[3] ? line[127:64] : line[63:0]);
    #1 check("uc_req_stall", stall_cpu, 1);
    check("uc_req_gate", {cache_wen, cache_ren}, 0);
    step;
    check("uc_en", w ? mem_wen : mem_ren, 1);
    check("uc_other_en", w ? mem_ren : mem_wen, 0);
    check("uc_addr", w ? mem_waddr : mem_raddr, a);
    if (w) begin
      check("uc_wmask", mem_wmask, a[3] ? {m, 8'h0} : {8'h0, m});
      check("uc_wdata", mem_wdata, {d, d});
    end
    for (int i = 1; i < lat; i++) begin
      step;
      check("uc_hold", stall_cpu, 1);
    end
    if (w) mem_wvalid = 1;
    else begin mem_rvalid = 1; mem_rdata = line; end
    #1 check("uc_valid_stall", stall_cpu, 1);
    check("uc_cm_gate", {cm_rvalid, cm_wvalid}, 0);
    step;
    mem_rvalid = 0; mem_wvalid = 0; mem_rdata = '0;
    #1 check("uc_unstall", stall_cpu, 0);
    if (!w) pop_check("uc_rdata");
    exp_uc++;
    step;
    wen_cpu = 0; ren_cpu = 0;
    #1 check("uc_count", uc_count, exp_uc);
    check("uc_idle", stall_cpu, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog total=%0d", total);
    $fatal(1, "timeout");
  end
  initial begin
    step; step;
    rst = 0;
    #1 check("rst_en_q", cache_en_q, 0);
    check("rst_count", uc_count, 0);
    check("rst_stall", stall_cpu, 0);
    check("rst_mem_en", {mem_ren, mem_wen}, 0);
    // cached read outside all regions
    cache_enable = 1;
    step;
    check("c_en_q", cache_en_q, 1);
    addr_cpu = 64'h1000; ren_cpu = 1; cache_rdata = 64'hC0FFEE_0001;
    cm_ren = 1; cm_raddr = 64'hABC0;
    sb.push_back(64'hC0FFEE_0001);
    #1 check("c_ren", cache_ren, 1);
    check("c_stall1", stall_cpu, 1);
    check("c_mem_raddr", mem_raddr, 64'hABC0);
    check("c_mem_ren", mem_ren, 1);
    step;
    check("c_stall2", stall_cpu, 1);
    cache_hit = 1; mem_rvalid = 1; mem_rdata = {64'h77, 64'h66};
    #1 check("c_stall3", stall_cpu, 0);
    check("c_cm_rvalid", cm_rvalid, 1);
    check("c_cm_rdata", cm_rdata, {64'h77, 64'h66});
    pop_check("c_rdata");
    step;
    ren_cpu = 0; cache_hit = 0; mem_rvalid = 0; cm_ren = 0; mem_rdata = '0;
    #1 check("c_count", uc_count, 0);
    // uncached region read, upper lane
    uc_go(64'h1000_0008, 0, 0, 0, 4, {64'hAAAA, 64'h5555});
    // cache disabled: writes in both lanes
    cache_enable = 0;
    step;
    check("d_en_q", cache_en_q, 0);
    uc_go(64'h20, 1, 64'h1234, 8'hFF, 2, '0);
    uc_go(64'h28, 1, 64'hBEEF, 8'h0F, 1, '0);
    // uncached read while the cache refill owns the port
    cm_ren = 1; cm_raddr = 64'h5000;
    addr_cpu = 64'h1000_0000; ren_cpu = 1;
    sb.push_back(64'h1111);
    #1 check("w_stall", stall_cpu, 1);
    step;
    check("w_mem_src", mem_raddr, 64'h5000);
    check("w_mem_ren", mem_ren, 1);
    check("w_stall2", stall_cpu, 1);
    step;
    check("w_mem_src2", mem_raddr, 64'h5000);
    mem_rvalid = 1; mem_rdata = {64'hF, 64'hE};
    #1 check("w_cm_rvalid", cm_rvalid, 1);
    check("w_cm_rdata", cm_rdata, {64'hF, 64'hE});
    step;
    mem_rvalid = 0; cm_ren = 0;
    #1 check("w_gap", mem_ren, 0);
    step;
    check("w_issue", mem_ren, 1);
    check("w_raddr", mem_raddr, 64'h1000_0000);
    mem_rvalid = 1; mem_rdata = {64'h2222, 64'h1111};
    #1 check("w_cm_gate", cm_rvalid, 0);
    step;
    mem_rvalid = 0;
    #1 check("w_unstall", stall_cpu, 0);
    pop_check("w_rdata");
    exp_uc++;
    step;
    ren_cpu = 0;
    #1 check("w_count", uc_count, exp_uc);
    // mode switch deferred behind an outstanding cache write
    cache_enable = 1;
    step;
    check("m_en_on", cache_en_q, 1);
    cm_wen = 1; cm_waddr = 64'h7000; cache_enable = 0;
    addr_cpu = 64'h1000; ren_cpu = 1;
    #1 check("m_block_stall", stall_cpu, 1);
    check("m_block_fwd", cache_ren, 0);
    check("m_mem_wen", mem_wen, 1);
    check("m_mem_waddr", mem_waddr, 64'h7000);
    step;
    check("m_hold1", cache_en_q, 1);
    step;
    check("m_hold2", cache_en_q, 1);
    ren_cpu = 0; mem_wvalid = 1;
    #1 check("m_cm_wvalid", cm_wvalid, 1);
    check("m_hold3", cache_en_q, 1);
    step;
    mem_wvalid = 0; cm_wen = 0;
    #1 check("m_switch", cache_en_q, 0);
    // reset in the middle of an uncached read
    addr_cpu = 64'h40; ren_cpu = 1;
    step;
    check("r_mem_ren", mem_ren, 1);
    rst = 1; ren_cpu = 0;
    step;
    rst = 0;
    #1 check("r_mem_ren_off", mem_ren, 0);
    check("r_stall", stall_cpu, 0);
    check("r_count_clr", uc_count, 0);
    mem_rvalid = 1; mem_rdata = {64'h9, 64'h8};
    step;
    mem_rvalid = 0;
    step;
    check("r_late_count", uc_count, 0);
    check("r_late_stall", stall_cpu, 0);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
